// File: rtl/stack_pkg.sv
// Shared types and default sizing for the parametrised LIFO stack.
// The operation code is the {push,pop} strobe pair taken as a 2-bit value.
package stack_pkg;

    localparam int STACK_DATA_W = 8;
    localparam int STACK_DEPTH  = 16;

    // Each encoding matches the {push,pop} bit pattern that produces it.
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_PUSH    = 2'b10,
        OP_POP     = 2'b01,
        OP_REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push_i, input logic pop_i);
        return stack_op_e'({push_i, pop_i});
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_W array with one synchronous write port
// and one asynchronous read port. Contents are never reset.
module stack_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with occupancy count, replace-top, registered
// top-of-stack output and sticky overflow/underflow flags.
module param_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              we_s;
    logic [AW-1:0]     waddr_s;
    logic [AW-1:0]     raddr_s;
    logic [DATA_W-1:0] rdata_s;
    logic              empty_s;
    logic              full_s;
    stack_op_e         op_s;

    assign op_s    = decode_op(push, pop);
    assign empty_s = (count_q == CNT_W'(0));
    assign full_s  = (count_q == CNT_W'(DEPTH));
    // Entry just below the current top; only consumed when count >= 2.
    assign raddr_s = AW'(count_q - CNT_W'(2));

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (we_s),
        .waddr_i (waddr_s),
        .wdata_i (data_in),
        .raddr_i (raddr_s),
        .rdata_o (rdata_s)
    );

    // Next-state decode for count, top value, memory write and error flags
    always_comb begin
        count_d = count_q;
        data_d  = data_q;
        we_s    = 1'b0;
        waddr_s = AW'(count_q);
        // A new error in the same cycle overrides the clear below.
        ovf_d   = clr_err ? 1'b0 : ovf_q;
        unf_d   = clr_err ? 1'b0 : unf_q;

        case (op_s)
            OP_PUSH: begin
                if (!full_s) begin
                    we_s    = 1'b1;
                    waddr_s = AW'(count_q);
                    count_d = count_q + CNT_W'(1);
                    data_d  = data_in;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty_s) begin
                    count_d = count_q - CNT_W'(1);
                    data_d  = (count_q == CNT_W'(1)) ? DATA_W'(0) : rdata_s;
                end else begin
                    unf_d = 1'b1;
                end
            end
            OP_REPLACE: begin
                we_s   = 1'b1;
                data_d = data_in;
                if (empty_s) begin
                    waddr_s = AW'(0);
                    count_d = CNT_W'(1);
                end else begin
                    waddr_s = AW'(count_q - CNT_W'(1));
                    count_d = count_q;
                end
            end
            default: begin
                count_d = count_q;
                data_d  = data_q;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= CNT_W'(0);
            data_q  <= DATA_W'(0);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign data_out  = data_q;
    assign count     = count_q;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: a DEPTH=4 byte stack and a
// DATA_W=13/DEPTH=8 instance for the parameter sweep.
module tb_param_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic       a_reset = 1'b0, a_push = 1'b0, a_pop = 1'b0, a_clr = 1'b0;
    logic [7:0] a_din = 8'h00;
    logic [7:0] a_dout;
    logic [2:0] a_count;
    logic       a_empty, a_full, a_ovf, a_unf;

    logic        b_reset = 1'b0, b_push = 1'b0, b_pop = 1'b0, b_clr = 1'b0;
    logic [12:0] b_din = 13'h0;
    logic [12:0] b_dout;
    logic [3:0]  b_count;
    logic        b_empty, b_full, b_ovf, b_unf;

    param_stack #(.DATA_W(8), .DEPTH(4)) dut_a (
        .clk(clk), .reset(a_reset), .push(a_push), .pop(a_pop), .data_in(a_din),
        .clr_err(a_clr), .data_out(a_dout), .count(a_count), .empty(a_empty),
        .full(a_full), .overflow(a_ovf), .underflow(a_unf)
    );

    param_stack #(.DATA_W(13), .DEPTH(8)) dut_b (
        .clk(clk), .reset(b_reset), .push(b_push), .pop(b_pop), .data_in(b_din),
        .clr_err(b_clr), .data_out(b_dout), .count(b_count), .empty(b_empty),
        .full(b_full), .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic step_a(input logic p, input logic q, input logic [7:0] d,
                          input logic c, input logic r);
        @(negedge clk);
        a_push = p; a_pop = q; a_din = d; a_clr = c; a_reset = r;
        @(posedge clk);
        #1;
        a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_reset = 1'b1;
    endtask

    task automatic step_b(input logic p, input logic q, input logic [12:0] d,
                          input logic r);
        @(negedge clk);
        b_push = p; b_pop = q; b_din = d; b_reset = r;
        @(posedge clk);
        #1;
        b_push = 1'b0; b_pop = 1'b0; b_reset = 1'b1;
    endtask

    task automatic test_reset();
        step_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 8'h5C, 1'b0, 1'b0);
        n_cmp++;
        if ({a_count, a_dout, a_empty, a_full, a_ovf, a_unf} !== {3'd0, 8'h00, 4'b1000}) begin
            n_err++;
            $display("FAIL reset: count=%0d dout=%h e/f/o/u=%b%b%b%b, expected 0 00 1000",
                     a_count, a_dout, a_empty, a_full, a_ovf, a_unf);
        end
    endtask

    task automatic test_lifo();
        logic [7:0] exp_top [3] = '{8'h22, 8'h11, 8'h00};
        step_a(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd3 || a_dout !== 8'h33 || a_empty !== 1'b0) begin
            n_err++;
            $display("FAIL lifo_push3: count=%0d dout=%h empty=%b, expected 3 33 0",
                     a_count, a_dout, a_empty);
        end
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
            n_cmp++;
            if (a_dout !== exp_top[i] || a_count !== 3'(2 - i) || a_empty !== (i == 2)) begin
                n_err++;
                $display("FAIL lifo_pop%0d: count=%0d dout=%h empty=%b, expected %0d %h %b",
                         i, a_count, a_dout, a_empty, 2 - i, exp_top[i], i == 2);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b1);
        end
        n_cmp++;
        if (a_full !== 1'b1 || a_count !== 3'd4 || a_dout !== 8'hA3) begin
            n_err++;
            $display("FAIL fill: full=%b count=%0d dout=%h, expected 1 4 a3", a_full, a_count, a_dout);
        end
        step_a(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd4 || a_dout !== 8'hA3 || a_ovf !== 1'b1 || a_unf !== 1'b0) begin
            n_err++;
            $display("FAIL overflow: count=%0d dout=%h ovf=%b unf=%b, expected 4 a3 1 0",
                     a_count, a_dout, a_ovf, a_unf);
        end
        step_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_cmp++;
        if (a_ovf !== 1'b0 || a_count !== 3'd4) begin
            n_err++;
            $display("FAIL ovf_clear: ovf=%b count=%0d, expected 0 4", a_ovf, a_count);
        end
        // Replace-top while full must not flag overflow.
        step_a(1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd4 || a_dout !== 8'h99 || a_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL replace_full: count=%0d dout=%h ovf=%b, expected 4 99 0",
                     a_count, a_dout, a_ovf);
        end
        step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd3 || a_dout !== 8'hA2) begin
            n_err++;
            $display("FAIL pop_after_full: count=%0d dout=%h, expected 3 a2", a_count, a_dout);
        end
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd0 || a_dout !== 8'h00 || a_empty !== 1'b1 || a_unf !== 1'b0) begin
            n_err++;
            $display("FAIL drain: count=%0d dout=%h empty=%b unf=%b, expected 0 00 1 0",
                     a_count, a_dout, a_empty, a_unf);
        end
    endtask

    task automatic test_underflow();
        step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd0 || a_dout !== 8'h00 || a_unf !== 1'b1 || a_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL underflow: count=%0d dout=%h unf=%b ovf=%b, expected 0 00 1 0",
                     a_count, a_dout, a_unf, a_ovf);
        end
        step_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_cmp++;
        if (a_unf !== 1'b0) begin
            n_err++;
            $display("FAIL unf_clear: unf=%b, expected 0", a_unf);
        end
        step_a(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        n_cmp++;
        if (a_unf !== 1'b1) begin
            n_err++;
            $display("FAIL unf_set_wins: unf=%b, expected 1", a_unf);
        end
        step_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_replace();
        step_a(1'b1, 1'b0, 8'h05, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 8'h06, 1'b0, 1'b1);
        step_a(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd2 || a_dout !== 8'h77 || a_ovf !== 1'b0 || a_unf !== 1'b0) begin
            n_err++;
            $display("FAIL replace: count=%0d dout=%h ovf=%b unf=%b, expected 2 77 0 0",
                     a_count, a_dout, a_ovf, a_unf);
        end
        step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd1 || a_dout !== 8'h05) begin
            n_err++;
            $display("FAIL replace_pop: count=%0d dout=%h, expected 1 05", a_count, a_dout);
        end
        step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        step_a(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd1 || a_dout !== 8'h44 || a_unf !== 1'b0 || a_empty !== 1'b0) begin
            n_err++;
            $display("FAIL replace_empty: count=%0d dout=%h unf=%b empty=%b, expected 1 44 0 0",
                     a_count, a_dout, a_unf, a_empty);
        end
        step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd0 || a_dout !== 8'h00 || a_unf !== 1'b0) begin
            n_err++;
            $display("FAIL replace_empty_pop: count=%0d dout=%h unf=%b, expected 0 00 0",
                     a_count, a_dout, a_unf);
        end
    endtask

    task automatic test_reset_mid();
        step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        n_cmp++;
        if ({a_count, a_dout, a_empty, a_full, a_ovf, a_unf} !== {3'd0, 8'h00, 4'b1000}) begin
            n_err++;
            $display("FAIL reset_mid: count=%0d dout=%h e/f/o/u=%b%b%b%b, expected 0 00 1000",
                     a_count, a_dout, a_empty, a_full, a_ovf, a_unf);
        end
        step_a(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
        n_cmp++;
        if (a_count !== 3'd1 || a_dout !== 8'h5A) begin
            n_err++;
            $display("FAIL push_after_reset: count=%0d dout=%h, expected 1 5a", a_count, a_dout);
        end
    endtask

    task automatic test_sweep();
        logic [12:0] vals [8] = '{13'h1FFF, 13'h0001, 13'h0002, 13'h0003,
                                  13'h0004, 13'h0005, 13'h0006, 13'h0007};
        logic [12:0] exp_v;
        step_b(1'b0, 1'b0, 13'h0, 1'b0);
        for (int i = 0; i < 8; i++) step_b(1'b1, 1'b0, vals[i], 1'b1);
        n_cmp++;
        if (b_count !== 4'd8 || b_full !== 1'b1 || b_dout !== 13'h0007) begin
            n_err++;
            $display("FAIL sweep_full: count=%0d full=%b dout=%h, expected 8 1 0007",
                     b_count, b_full, b_dout);
        end
        step_b(1'b1, 1'b0, 13'h0ABC, 1'b1);
        n_cmp++;
        if (b_ovf !== 1'b1 || b_count !== 4'd8 || b_dout !== 13'h0007) begin
            n_err++;
            $display("FAIL sweep_ovf: ovf=%b count=%0d dout=%h, expected 1 8 0007",
                     b_ovf, b_count, b_dout);
        end
        for (int k = 1; k <= 8; k++) begin
            step_b(1'b0, 1'b1, 13'h0, 1'b1);
            exp_v = (k == 8) ? 13'h0000 : vals[7 - k];
            n_cmp++;
            if (b_dout !== exp_v || b_count !== 4'(8 - k) || b_empty !== (k == 8)) begin
                n_err++;
                $display("FAIL sweep_pop%0d: count=%0d dout=%h empty=%b, expected %0d %h %b",
                         k, b_count, b_dout, b_empty, 8 - k, exp_v, k == 8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_replace();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised hardware LIFO stack for the Processador datapath. It replaces the fixed 8-bit stack that drives stack_output/empty/full.
- Generalised in data width and depth. Adds occupancy count, combined push+pop (replace-top), sticky overflow/underflow error flags with clear, and a registered top-of-stack output.
- Sits between the control unit (push/pop strobes) and the ALU/RAM data bus.

Parameters:
- DATA_W, 8, width of each stack entry in bits.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (holds 0..DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- push  input  1  push request for this cycle.
- pop  input  1  pop request for this cycle.
- data_in  input  DATA_W  value to push, or replacement top value for push+pop.
- clr_err  input  1  clears the overflow and underflow flags.
- data_out  output  DATA_W  registered top-of-stack value; 0 when empty.
- count  output  CNT_W  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was rejected because the stack was full.
- underflow  output  1  sticky: a pop was rejected because the stack was empty.

Behaviour:
- Reset (reset==0 at posedge): count=0, data_out=0, overflow=0, underflow=0, empty=1, full=0. Memory contents are not cleared.
- Reset mid-operation discards all entries. Push/pop in the reset cycle are ignored.
- empty and full are decoded combinationally from the registered count, so they carry no extra latency.
- Operation by {push,pop} at each non-reset posedge:
  - 00: hold all state.
  - 10, not full: mem[count] <= data_in; count++; data_out <= data_in.
  - 10, full: no write, count unchanged; overflow <= 1.
  - 01, not empty: count--; data_out <= mem[count-2], or 0 if count==1.
  - 01, empty: no change; underflow <= 1.
  - 11, not empty (including full): mem[count-1] <= data_in; count unchanged; data_out <= data_in. No flag is set.
  - 11, empty: behaves as push only. count becomes 1, data_out = data_in, underflow is not set.
- Latency: data_out, count, empty and full reflect an operation in the cycle after the edge that performed it (one-cycle latency).
- Popped data is the data_out value presented before the pop edge. The consumer samples data_out, then asserts pop.
- Pointer is count-based with no wrap-around. Writes never exceed index DEPTH-1; reads never go below index 0.
- Error flags:
  - clr_err==1 clears both flags.
  - If clr_err and a new error occur in the same cycle, the set wins (flag ends at 1).
  - Flags never affect push/pop acceptance.
- Memory: synchronous-write array of DEPTH x DATA_W. The next-top read uses the combinational read of mem[count-2]; this maps to distributed RAM or registers.
- Arithmetic: count is unsigned CNT_W. Index math is done at CNT_W width and truncated to $clog2(DEPTH) bits for addressing.

Decomposition:
- Shared package stack_pkg holds:
  - the typedef stack_op_e {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE}, decoded from {push,pop};
  - the default constants STACK_DATA_W=8 and STACK_DEPTH=16, used by Processador.
- One sub-module: stack_mem. It is a parametrised DEPTH x DATA_W array with one synchronous write port and one asynchronous read port.
- Control, count and flag logic stay in param_stack. No FSM beyond the count register.

Test Plan (DATA_W=8, DEPTH=4):
- Reset and basic LIFO: hold reset=0 for 2 cycles, then push 0x11, 0x22, 0x33. Expect count=3 and data_out=0x33. Pop three times; data_out goes 0x22, 0x11, 0x00, and empty=1 after the third pop.
- Overflow: push 0xA0..0xA3 (full=1), then push 0xFF. Expect count=4, data_out=0xA3, overflow=1. Pulse clr_err; overflow returns to 0.
- Underflow: from empty, pop. Expect count=0, data_out=0, underflow=1. Pop and clr_err in the same cycle leaves underflow=1.
- Simultaneous push+pop:
  - Stack [0x05, 0x06], push+pop with 0x77: count=2, data_out=0x77; then pop gives data_out=0x05.
  - From full, push+pop: no overflow.
  - From empty, push+pop with 0x44: count=1, data_out=0x44, underflow=0.
- Reset mid-operation: with count=3, assert reset=0 together with push=1. Next cycle count=0, data_out=0, empty=1, flags=0. A subsequent push of 0x5A gives data_out=0x5A and count=1.
- Parameter sweep: DATA_W=13, DEPTH=8. Fill with 0x1FFF, 0x0001, ... Verify full at count=8, correct LIFO order, and count width of 4 bits.
